// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, rectangle descriptor type and hit-index sizing helper
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    typedef struct packed {
        logic       en;
        logic [9:0] x0;
        logic [9:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
        logic [2:0] rgb;
    } rect_t;
    function automatic int hit_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/vga_rect_hit.sv
// vga_rect_hit: strict containment test for one slot; with RECT_MOTION_EN also the per-frame bounce step
module vga_rect_hit
    import vga_pkg::*;
`ifdef RECT_MOTION_EN
#(
    parameter int STEP = 2
)
`endif
(
    input  rect_t      r,
    input  logic [9:0] x,
    input  logic [8:0] y,
`ifdef RECT_MOTION_EN
    input  logic       dx,
    input  logic       dy,
    output rect_t      nxt,
    output logic       ndx,
    output logic       ndy,
`endif
    output logic       hit
);
    assign hit = r.en && x > r.x0 && x < r.x1 && y > r.y0 && y < r.y1;
`ifdef RECT_MOTION_EN
    logic bx, by;
    // Reaching an edge counts as crossing: flip direction and hold this frame.
    always_comb begin
        bx = dx ? 11'(r.x1) + 11'(STEP) >= 11'(H_ACTIVE) : r.x0 <= 10'(STEP);
        by = dy ? 10'(r.y1) + 10'(STEP) >= 10'(V_ACTIVE) : r.y0 <= 9'(STEP);
        nxt = r;
        nxt.x0 = (!r.en || bx) ? r.x0 : dx ? r.x0 + 10'(STEP) : r.x0 - 10'(STEP);
        nxt.x1 = (!r.en || bx) ? r.x1 : dx ? r.x1 + 10'(STEP) : r.x1 - 10'(STEP);
        nxt.y0 = (!r.en || by) ? r.y0 : dy ? r.y0 + 9'(STEP) : r.y0 - 9'(STEP);
        nxt.y1 = (!r.en || by) ? r.y1 : dy ? r.y1 + 9'(STEP) : r.y1 - 9'(STEP);
        ndx = (r.en && bx) ? !dx : dx;
        ndy = (r.en && by) ? !dy : dy;
    end
`endif
endmodule

// File: rtl/vga_rect_scheduler.sv
// vga_rect_scheduler: NUM_RECT-slot priority rectangle overlay; shadow config is committed at the frame boundary.
// Define RECT_MOTION_EN for rectangles that step and bounce every frame.
module vga_rect_scheduler
    import vga_pkg::*;
#(
    parameter int NUM_RECT = 4
`ifdef RECT_MOTION_EN
    ,
    parameter int STEP = 2
`endif
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic       i_pix_stb,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_idx,
    input  logic       cfg_en,
    input  logic [9:0] cfg_x0,
    input  logic [9:0] cfg_x1,
    input  logic [8:0] cfg_y0,
    input  logic [8:0] cfg_y1,
    input  logic [2:0] cfg_rgb,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic [2:0] o_hit_idx,
    output logic       o_commit
);
    localparam int HW = hit_w(NUM_RECT);
    rect_t shadow [NUM_RECT];
    rect_t active [NUM_RECT];
    logic [NUM_RECT-1:0] hit;
    logic [HW-1:0] win;
    logic [2:0] rgb;
    logic dirty, evt, commit, we, blank;
    assign evt = i_pix_stb && i_x == 10'd0 && i_y == 9'(V_ACTIVE);
    assign commit = evt && dirty;
    assign cfg_ready = !commit;
    assign we = cfg_valid && cfg_ready && int'(cfg_idx) < NUM_RECT;
    assign blank = i_x >= 10'(H_ACTIVE) || i_y >= 9'(V_ACTIVE);
`ifdef RECT_MOTION_EN
    rect_t nxt [NUM_RECT];
    logic [NUM_RECT-1:0] dx, dy, ndx, ndy;
    assign o_commit = evt;
`else
    assign o_commit = commit;
`endif
    for (genvar g = 0; g < NUM_RECT; g++) begin : g_slot
`ifdef RECT_MOTION_EN
        vga_rect_hit #(.STEP(STEP)) u_hit (.r(active[g]), .x(i_x), .y(i_y), .dx(dx[g]), .dy(dy[g]),
                                          .nxt(nxt[g]), .ndx(ndx[g]), .ndy(ndy[g]), .hit(hit[g]));
`else
        vga_rect_hit u_hit (.r(active[g]), .x(i_x), .y(i_y), .hit(hit[g]));
`endif
    end
    always_ff @(posedge CLK or negedge RST_BTN)
        if (!RST_BTN) begin
            dirty <= 1'b0;
            for (int i = 0; i < NUM_RECT; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RECT; i++)
                if (we && cfg_idx == 3'(i)) shadow[i] <= '{cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_rgb};
            dirty <= we || (dirty && !commit);
        end
    always_ff @(posedge CLK or negedge RST_BTN)
        if (!RST_BTN) begin
            for (int i = 0; i < NUM_RECT; i++) active[i] <= '0;
`ifdef RECT_MOTION_EN
            dx <= '1;
            dy <= '1;
`endif
        end else if (commit) begin
            for (int i = 0; i < NUM_RECT; i++) active[i] <= shadow[i];
`ifdef RECT_MOTION_EN
            dx <= '1;
            dy <= '1;
        end else if (evt) begin
            for (int i = 0; i < NUM_RECT; i++) active[i] <= nxt[i];
            dx <= ndx;
            dy <= ndy;
`endif
        end
    // Scan from lowest priority up so the lowest hitting index overwrites last.
    always_comb begin
        win = HW'(NUM_RECT);
        rgb = '0;
        for (int i = NUM_RECT - 1; i >= 0; i--) begin
            win = hit[i] ? HW'(i) : win;
            rgb = hit[i] ? active[i].rgb : rgb;
        end
    end
    always_ff @(posedge CLK or negedge RST_BTN)
        if (!RST_BTN) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            o_hit_idx <= 3'(NUM_RECT);
        end else if (i_pix_stb) begin
            VGA_R <= {8{rgb[2] & ~blank}};
            VGA_G <= {8{rgb[1] & ~blank}};
            VGA_B <= {8{rgb[0] & ~blank}};
            o_hit_idx <= blank ? 3'(NUM_RECT) : 3'(win);
        end
endmodule

// File: tb/tb_vga_rect_scheduler.sv
// tb_vga_rect_scheduler: directed stimulus with a rectangle-list model and per-cycle output comparison
module tb_vga_rect_scheduler;
    import vga_pkg::*;
    localparam int NR = 4;
    logic CLK = 0, RST_BTN = 1, i_pix_stb = 0;
    logic [9:0] i_x = 0;
    logic [8:0] i_y = 0;
    logic cfg_valid = 0, cfg_en = 0, cfg_ready;
    logic [2:0] cfg_idx = 0, cfg_rgb = 0;
    logic [9:0] cfg_x0 = 0, cfg_x1 = 0;
    logic [8:0] cfg_y0 = 0, cfg_y1 = 0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic [2:0] o_hit_idx;
    logic o_commit;
    int n_chk = 0, n_err = 0;
    rect_t m_sh [NR];
    rect_t m_act [NR];
    bit m_dirty = 0, cmp_en = 0;
    int exp_idx = NR;
    logic [2:0] exp_rgb = 0;

    always #5 CLK = ~CLK;

    vga_rect_scheduler #(.NUM_RECT(NR)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1), .cfg_rgb(cfg_rgb),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .o_hit_idx(o_hit_idx), .o_commit(o_commit)
    );

    function automatic void chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // First enabled rectangle in list order that strictly contains the visible pixel wins.
    function automatic void model_pix(input int x, input int y, output int idx, output logic [2:0] rgb);
        idx = NR;
        rgb = 0;
        if (x < 640 && y < 480)
            for (int i = 0; i < NR; i++)
                if (idx == NR && m_act[i].en && x > int'(m_act[i].x0) && x < int'(m_act[i].x1)
                    && y > int'(m_act[i].y0) && y < int'(m_act[i].y1)) begin
                    idx = i;
                    rgb = m_act[i].rgb;
                end
    endfunction

    always @(negedge CLK)
        if (cmp_en) begin
            chk("hit_idx", int'(o_hit_idx), exp_idx);
            chk("vga_r", int'(VGA_R), exp_rgb[2] ? 255 : 0);
            chk("vga_g", int'(VGA_G), exp_rgb[1] ? 255 : 0);
            chk("vga_b", int'(VGA_B), exp_rgb[0] ? 255 : 0);
        end

    task automatic tick();
        int ni;
        logic [2:0] nr;
        bit stb, cm, wr;
        #1;
        stb = i_pix_stb;
        cm = stb && i_x == 0 && i_y == 480 && m_dirty;
        wr = cfg_valid && !cm;
        chk("cfg_ready", int'(cfg_ready), int'(!cm));
        chk("o_commit", int'(o_commit), int'(cm));
        model_pix(int'(i_x), int'(i_y), ni, nr);
        @(posedge CLK);
        #1;
        if (stb) begin
            exp_idx = ni;
            exp_rgb = nr;
        end
        if (cm) begin
            for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
            m_dirty = 0;
        end
        if (wr && int'(cfg_idx) < NR) begin
            m_sh[int'(cfg_idx)] = '{cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_rgb};
            m_dirty = 1;
        end
    endtask

    task automatic pix(input int x, input int y, input bit stb = 1);
        i_x = 10'(x);
        i_y = 9'(y);
        i_pix_stb = stb;
        tick();
    endtask

    task automatic set_cfg(input int idx, input int en, input int x0, input int x1, input int y0, input int y1, input int rgb);
        cfg_idx = 3'(idx);
        cfg_en = en[0];
        cfg_x0 = 10'(x0);
        cfg_x1 = 10'(x1);
        cfg_y0 = 9'(y0);
        cfg_y1 = 9'(y1);
        cfg_rgb = 3'(rgb);
    endtask

    task automatic wr(input int idx, input int en, input int x0, input int x1, input int y0, input int y1, input int rgb);
        set_cfg(idx, en, x0, x1, y0, y1, rgb);
        cfg_valid = 1;
        i_pix_stb = 0;
        tick();
        cfg_valid = 0;
    endtask

    task automatic hard_reset();
        RST_BTN = 0;
        for (int i = 0; i < NR; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
        end
        m_dirty = 0;
        exp_idx = NR;
        exp_rgb = 0;
        #1;
        chk("rst_vga", int'({VGA_R, VGA_G, VGA_B}), 0);
        chk("rst_idx", int'(o_hit_idx), NR);
        chk("rst_ready", int'(cfg_ready), 1);
        @(posedge CLK);
        #1;
        RST_BTN = 1;
    endtask

    task automatic expect_lit(input string name, input int idx, input int r, input int g, input int b);
        chk({name, "_idx"}, int'(o_hit_idx), idx);
        chk({name, "_r"}, int'(VGA_R), r);
        chk({name, "_g"}, int'(VGA_G), g);
        chk({name, "_b"}, int'(VGA_B), b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        hard_reset();
        cmp_en = 1;
        // Write is invisible until the frame-boundary commit.
        wr(0, 1, 120, 280, 40, 200, 3'b010);
        pix(200, 100);
        expect_lit("precommit", 4, 0, 0, 0);
        pix(0, 480);
        pix(200, 100);
        expect_lit("postcommit", 0, 0, 255, 0);
        // Strict bounds and degenerate slot.
        pix(120, 100);
        expect_lit("x_eq_x0", 4, 0, 0, 0);
        pix(121, 100);
        expect_lit("x_x0p1", 0, 0, 255, 0);
        pix(279, 100);
        expect_lit("x_x1m1", 0, 0, 255, 0);
        pix(280, 100);
        expect_lit("x_eq_x1", 4, 0, 0, 0);
        pix(200, 40);
        chk("y_eq_y0", int'(o_hit_idx), 4);
        pix(200, 199);
        chk("y_y1m1", int'(o_hit_idx), 0);
        wr(2, 1, 10, 11, 0, 479, 3'b111);
        wr(3, 1, 600, 1000, 0, 500, 3'b001);
        pix(0, 480);
        pix(10, 100);
        chk("empty_x0", int'(o_hit_idx), 4);
        pix(11, 100);
        chk("empty_x1", int'(o_hit_idx), 4);
        pix(650, 100);
        expect_lit("hblank", 4, 0, 0, 0);
        pix(620, 490);
        chk("vblank", int'(o_hit_idx), 4);
        pix(620, 100);
        expect_lit("slot3", 3, 0, 0, 255);
        pix(200, 100, 0);
        expect_lit("hold", 3, 0, 0, 255);
        // Clean frame boundary and out-of-range index produce no commit.
        i_x = 0; i_y = 480; i_pix_stb = 1;
        #1;
        chk("idle_commit", int'(o_commit), 0);
        tick();
        wr(5, 1, 0, 639, 0, 479, 3'b111);
        i_x = 0; i_y = 480; i_pix_stb = 1;
        #1;
        chk("bad_idx_commit", int'(o_commit), 0);
        tick();
        // Priority: slot0 green over slot1 red.
        wr(1, 1, 200, 360, 40, 200, 3'b100);
        pix(0, 480);
        pix(250, 100);
        expect_lit("overlap", 0, 0, 255, 0);
        pix(300, 100);
        expect_lit("slot1", 1, 255, 0, 0);
        // Write held across a commit lands one cycle later and waits a frame.
        wr(3, 1, 400, 500, 300, 400, 3'b100);
        set_cfg(2, 1, 50, 100, 50, 100, 3'b010);
        cfg_valid = 1;
        i_x = 0; i_y = 480; i_pix_stb = 1;
        #1;
        chk("held_ready_lo", int'(cfg_ready), 0);
        chk("held_commit", int'(o_commit), 1);
        tick();
        i_x = 450; i_y = 350;
        #1;
        chk("held_ready_hi", int'(cfg_ready), 1);
        tick();
        cfg_valid = 0;
        expect_lit("new_slot3", 3, 255, 0, 0);
        pix(75, 75);
        chk("held_not_yet", int'(o_hit_idx), 4);
        pix(0, 480);
        pix(75, 75);
        expect_lit("held_visible", 2, 0, 255, 0);
        // Mid-line reset blanks at once and the frame stays black.
        pix(250, 100, 1);
        i_x = 75; i_y = 75;
        #2;
        hard_reset();
        pix(75, 75);
        pix(0, 480);
        pix(75, 75);
        expect_lit("post_reset", 4, 0, 0, 0);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
